float_add_pipe: RTL and testbench
=================================

FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port floatA  input  W  operand A: sign, biased exponent, mantissa.
REQ-008 SHALL have port floatB  input  W  operand B, same format.
REQ-009 SHALL have port op_sub  input  1  1 = A-B (B sign inverted), 0 = A+B.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  W  result.
REQ-013 SHALL have port ovf  output  1  result overflowed, valid with out_valid.
REQ-014 SHALL have port unf  output  1  result underflowed to zero, valid with out_valid.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 zero detect, exponent compare, align; S2 add/subtract; S3 normalise, round, pack.
REQ-016 SHALL accept a transfer when in_valid and in_ready are both 1; transfer completes when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = ~(out_valid & ~out_ready); when out_valid is high and out_ready low, all stages hold.
REQ-018 SHALL present the result exactly 3 cycles after acceptance when no stall occurs, at one result per cycle.
REQ-019 SHALL keep sum/ovf/unf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL treat an operand with zero exponent field as zero (subnormals flushed); zero+X returns X bit-exact (sign adjusted by op_sub).
REQ-021 SHALL return +0 with ovf=unf=0 for exact cancellation.
REQ-022 SHALL compute alignment on implied-1 significands with MAN_W+4 bits (guard, round, sticky, carry); shifts >= MAN_W+3 collapse into sticky.
REQ-023 SHALL, on carry-out, shift right one and increment exponent; on cancellation, shift left by leading-zero count and decrement exponent.
REQ-024 SHALL, when the biased exponent reaches or exceeds all-ones, output sign, exponent all-ones, zero mantissa, ovf=1.
REQ-025 SHALL, when the biased exponent drops to 0 or below, output +0, unf=1.
REQ-026 SHALL not interpret NaN/inf inputs specially; all-ones-exponent inputs are ordinary values.

Reset
REQ-027 SHALL on rst clear all stage valid bits; out_valid=0, sum=0, ovf=0, unf=0, in_ready=1, asynchronously.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result from them appears after rst deasserts.
REQ-029 SHALL accept a new operand on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with FLOAT_ADD_PIPE_RNE_EN defined, round to nearest, ties to even, using guard/round/sticky; rounding carry renormalises and may raise ovf.
REQ-031 SHALL, without FLOAT_ADD_PIPE_RNE_EN, truncate (guard/round/sticky discarded).

Verification (EXP_W=5, MAN_W=10)
REQ-032 SHALL test: A=0x3C00, B=0x3C00, op_sub=0 -> sum=0x4000 exactly 3 cycles later, ovf=unf=0.
REQ-033 SHALL test: A=0x3C00, B=0x3C00, op_sub=1 -> sum=0x0000, ovf=unf=0; A=0x0000, B=0xC500, op_sub=0 -> sum=0xC500.
REQ-034 SHALL test: A=0x7BFF, B=0x7BFF, op_sub=0 -> sum=0x7C00, ovf=1; A=0x0400, B=0x0401, op_sub=1 -> sum=0x0000, unf=1.
REQ-035 SHALL test: A=0x3C01, B=0x1000 -> sum=0x3C02 with FLOAT_ADD_PIPE_RNE_EN defined, 0x3C01 without it.
REQ-036 SHALL test: 8 back-to-back pairs with out_ready low for 5 cycles mid-stream -> in_ready drops, results in order, none lost or duplicated.
REQ-037 SHALL test: rst asserted with 2 ops in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/float_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: align, add, normalise/round/pack.
// Define FLOAT_ADD_PIPE_RNE_EN for round-to-nearest-even; the default build truncates.
module float_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   floatA,
  input  logic [EXP_W+MAN_W:0]   floatB,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;             // implied 1, mantissa, guard, round, sticky
  localparam int LZW = $clog2(SW);
  localparam int ES  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic signed [ES-1:0] EMAX_S = ES'((1 << EXP_W) - 1);

  // A single global stall: nothing moves while a finished result waits.
  logic advance;
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // ---------------- S1: zero detect, magnitude compare, align ----------------
  logic             sa, sb, za, zb, a_big;
  logic [EXP_W-1:0] ea, eb, ediff;
  logic [MAN_W-1:0] ma, mb;
  logic [SW-1:0]    big_sig, small_sig, small_al, mask;
  logic             byp_d;
  logic [W-1:0]     bypw_d;

  // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    sa        = floatA[W-1];
    ea        = floatA[W-2 -: EXP_W];
    ma        = floatA[MAN_W-1:0];
    sb        = floatB[W-1] ^ op_sub;
    eb        = floatB[W-2 -: EXP_W];
    mb        = floatB[MAN_W-1:0];
    za        = (ea == '0);
    zb        = (eb == '0);
    a_big     = ({ea, ma} >= {eb, mb});
    ediff     = a_big ? (ea - eb) : (eb - ea);
    big_sig   = {1'b1, (a_big ? ma : mb), 3'b000};
    small_sig = {1'b1, (a_big ? mb : ma), 3'b000};
    mask      = '0;
    small_al  = SW'(1);
    if (int'(ediff) < MAN_W + 3) begin
      mask     = (SW'(1) << ediff) - SW'(1);
      small_al = (small_sig >> ediff) | SW'(|(small_sig & mask));
    end
    byp_d  = za | zb;
    bypw_d = za ? {sb, eb, mb} : floatA;
  end

  logic             v1, byp1, sign1, sub1;
  logic [W-1:0]     bypw1;
  logic [EXP_W-1:0] exp1;
  logic [SW-1:0]    big1, small1;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          v1 <= 1'b0;
    else if (advance) v1 <= in_valid;
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      byp1   <= byp_d;
      bypw1  <= bypw_d;
      sign1  <= a_big ? sa : sb;
      sub1   <= sa ^ sb;
      exp1   <= a_big ? ea : eb;
      big1   <= big_sig;
      small1 <= small_al;
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic [SW:0] raw_d;
  assign raw_d = sub1 ? ({1'b0, big1} - {1'b0, small1})
                      : ({1'b0, big1} + {1'b0, small1});

  logic             v2, byp2, sign2;
  logic [W-1:0]     bypw2;
  logic [EXP_W-1:0] exp2;
  logic [SW:0]      raw2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          v2 <= 1'b0;
    else if (advance) v2 <= v1;
  end

  always_ff @(posedge clk) begin
    if (advance && v1) begin
      byp2  <= byp1;
      bypw2 <= bypw1;
      sign2 <= sign1;
      exp2  <= exp1;
      raw2  <= raw_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]        lz;
  logic [SW-1:0]         norm;
  logic signed [ES-1:0]  e_n, e_f;
  logic [MAN_W-1:0]      man_f;
  logic [W-1:0]          sum_d;
  logic                  ovf_d, unf_d;
`ifdef FLOAT_ADD_PIPE_RNE_EN
  logic                  rnd_up;
  logic [MAN_W+1:0]      man_r;
  logic                  unused_man_r;
  assign unused_man_r = man_r[MAN_W];
`else
  logic                  unused_grs;
  assign unused_grs = ^{norm[SW-1], norm[2:0]};
`endif

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) begin
      if (raw2[i]) lz = LZW'(SW - 1 - i);
    end
    // Carry-out shifts right once, folding the dropped bit into sticky.
    if (raw2[SW]) begin
      norm = raw2[SW:1] | SW'(raw2[0]);
      e_n  = ES'(exp2) + ES'(1);
    end else begin
      norm = raw2[SW-1:0] << lz;
      e_n  = ES'(exp2) - ES'(lz);
    end
`ifdef FLOAT_ADD_PIPE_RNE_EN
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r  = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_up);
    if (man_r[MAN_W+1]) begin
      e_f   = e_n + ES'(1);
      man_f = '0;
    end else begin
      e_f   = e_n;
      man_f = man_r[MAN_W-1:0];
    end
`else
    e_f   = e_n;
    man_f = norm[SW-2:3];
`endif
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (byp2) begin
      sum_d = bypw2;
    end else if (raw2 == '0) begin
      sum_d = '0;
    end else if (e_f >= EMAX_S) begin
      sum_d = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_f[ES-1] || (e_f == '0)) begin
      sum_d = '0;
      unf_d = 1'b1;
    end else begin
      sum_d = {sign2, e_f[EXP_W-1:0], man_f};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        sum <= sum_d;
        ovf <= ovf_d;
        unf <= unf_d;
      end
    end
  end

endmodule

// File: tb/tb_float_add_pipe.sv
// Bench for float_add_pipe (EXP_W=5, MAN_W=10): directed vectors with literal results plus an
// exact-arithmetic reference model checked on every output cycle.
module tb_float_add_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 16;

  logic         clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready, ovf, unf;
  logic [W-1:0] floatA, floatB, sum;

  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  bit   saw_inr_low = 0;
  logic rdy_exp;
  logic [17:0] exp_q[$];   // {ovf, unf, sum}

  float_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .floatA(floatA), .floatB(floatB), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .unf(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact sum as scaled integers, then truncate or round-to-nearest-even the magnitude.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic   sa, sb, sgn;
    int     ea, eb, emin, p, er, sh;
    longint va, vb, s, mag, kept;
`ifdef FLOAT_ADD_PIPE_RNE_EN
    longint rem, half;
`endif
    sa = a[15];
    sb = b[15] ^ sub;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0) return {2'b00, sb, b[14:0]};
    if (eb == 0) return {2'b00, a};
    emin = (ea < eb) ? ea : eb;
    va   = longint'({1'b1, a[9:0]}) << (ea - emin);
    vb   = longint'({1'b1, b[9:0]}) << (eb - emin);
    s    = (sa ? -va : va) + (sb ? -vb : vb);
    if (s == 0) return 18'h0;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    er = emin + p - MAN_W;
    if (p > MAN_W) begin
      sh   = p - MAN_W;
      kept = mag >> sh;
`ifdef FLOAT_ADD_PIPE_RNE_EN
      rem  = mag - (kept << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept++;
      if (kept == (longint'(1) << (MAN_W + 1))) begin
        kept = kept >> 1;
        er++;
      end
`endif
    end else begin
      kept = mag << (MAN_W - p);
    end
    if (er >= 31) return {2'b10, sgn, 5'h1f, 10'h000};
    if (er <= 0)  return {2'b01, 16'h0000};
    return {2'b00, sgn, 5'(er), kept[9:0]};
  endfunction

  // Compare process: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      rdy_exp = ~(out_valid & ~out_ready);
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, rdy_exp});
      if (!in_ready) saw_inr_low = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got sum %h with nothing pending", sum);
        end else begin
          check("model_out", {14'b0, ovf, unf, sum}, {14'b0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(floatA, floatB, op_sub));
    end
  end

  // One operation into an empty pipe; result due after the third rising edge.
  task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [17:0] exp);
    int n;
    check({name, "_model"}, {14'b0, model(a, b, sub)}, {14'b0, exp});
    out_ready = 1'b1;
    floatA    = a;
    floatB    = b;
    op_sub    = sub;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_result"}, {14'b0, ovf, unf, sum}, {14'b0, exp});
    @(posedge clk); #1;
  endtask

  task automatic run_stream();
    logic [32:0] vec [8];   // {op_sub, A, B}
    int start, n;
    vec[0] = {1'b0, 16'h3C00, 16'h3C00};
    vec[1] = {1'b1, 16'h3C00, 16'h3800};
    vec[2] = {1'b0, 16'h4500, 16'hC200};
    vec[3] = {1'b0, 16'h0400, 16'h0400};
    vec[4] = {1'b0, 16'h7BFF, 16'h7BFF};
    vec[5] = {1'b0, 16'h3555, 16'h2AAA};
    vec[6] = {1'b1, 16'h5A00, 16'h5A00};
    vec[7] = {1'b0, 16'h0000, 16'h3C00};
    start       = n_out;
    saw_inr_low = 1'b0;
    out_ready   = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int guard;
          {op_sub, floatA, floatB} = vec[i];
          in_valid = 1'b1;
          guard = 0;
          @(negedge clk);
          while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 50) check("stream_accept_timeout", guard, 0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stream_count", n_out - start, 8);
    check("stream_pending", exp_q.size(), 0);
    check("stream_in_ready_dropped", {31'b0, saw_inr_low}, 32'd1);
  endtask

  initial begin
    int n_hi;
    rst = 1'b0; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    floatA = '0; floatB = '0;
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_unf", {31'b0, unf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First op is presented straight after release and must be taken on the next edge.
    run_single("add_one",    16'h3C00, 16'h3C00, 1'b0, {2'b00, 16'h4000});
    run_single("sub_cancel", 16'h3C00, 16'h3C00, 1'b1, {2'b00, 16'h0000});
    run_single("zero_a",     16'h0000, 16'hC500, 1'b0, {2'b00, 16'hC500});
    run_single("zero_a_sub", 16'h0000, 16'h4500, 1'b1, {2'b00, 16'hC500});
    run_single("zero_b",     16'h4248, 16'h0000, 1'b1, {2'b00, 16'h4248});
    run_single("ovf",        16'h7BFF, 16'h7BFF, 1'b0, {2'b10, 16'h7C00});
    run_single("unf",        16'h0400, 16'h0401, 1'b1, {2'b01, 16'h0000});
    run_single("add_half",   16'h3C00, 16'h3800, 1'b0, {2'b00, 16'h3E00});
    run_single("sub_neg",    16'h3C00, 16'h3E00, 1'b1, {2'b00, 16'hB800});
    run_single("mixed_sign", 16'hBC00, 16'h4000, 1'b0, {2'b00, 16'h3C00});
    run_single("min_norm",   16'h0400, 16'h0400, 1'b0, {2'b00, 16'h0800});
    run_single("collapse",   16'h3C00, 16'h0400, 1'b0, {2'b00, 16'h3C00});
`ifdef FLOAT_ADD_PIPE_RNE_EN
    run_single("tie_even",   16'h3C01, 16'h1000, 1'b0, {2'b00, 16'h3C02});
    run_single("round_ovf",  16'h7BFF, 16'h4C00, 1'b0, {2'b10, 16'h7C00});
    run_single("sub_sticky", 16'h3C00, 16'h0400, 1'b1, {2'b00, 16'h3C00});
`else
    run_single("tie_even",   16'h3C01, 16'h1000, 1'b0, {2'b00, 16'h3C01});
    run_single("round_ovf",  16'h7BFF, 16'h4C00, 1'b0, {2'b00, 16'h7BFF});
    run_single("sub_sticky", 16'h3C00, 16'h0400, 1'b1, {2'b00, 16'h3BFF});
`endif

    run_stream();

    // Two operations in flight, the older one parked at the output, then reset.
    out_ready = 1'b0;
    floatA = 16'h7BFF; floatB = 16'h7BFF; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    floatA = 16'h3C00; floatB = 16'h3800;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_out_valid", {31'b0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sum", {16'b0, sum}, 32'd0);
    check("midrst_ovf", {31'b0, ovf}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    n_hi = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) n_hi++;
    end
    check("rst_no_stale", n_hi, 0);
    run_single("post_rst", 16'h4000, 16'h3C00, 1'b1, {2'b00, 16'h3C00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
